// File: rtl/cube_pkg.sv
// -----------------------------------------------------------------------------
// cube_pkg
// Shared constants and types for the cube result writer slice.
//   DATA_LEN  : bits per element (must match the global data_len)
//   NUM_CH    : channels per frame, one channel per output beat
//   CH_ELEMS  : elements per channel
//   CH_W      : width of a channel index
//   BEAT_W    : width of one output beat (one channel)
//   FRAME_W   : width of a full result frame
//   NUM_DATA  : elements per frame (re-export of the existing num_data count)
// -----------------------------------------------------------------------------
package cube_pkg;

    localparam int DATA_LEN = 16;
    localparam int NUM_CH   = 32;
    localparam int CH_ELEMS = 12;

    localparam int CH_W     = $clog2(NUM_CH);
    localparam int BEAT_W   = CH_ELEMS * DATA_LEN;
    localparam int FRAME_W  = NUM_CH * BEAT_W;

    localparam int NUM_DATA = NUM_CH * CH_ELEMS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } wr_state_e;

    // True when the given channel index is the final beat of a frame.
    function automatic logic is_last_ch(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(NUM_CH - 1));
    endfunction

endpackage

// File: rtl/cube_frame_reg.sv
// -----------------------------------------------------------------------------
// cube_frame_reg
// Wide capture register for one result frame plus a channel-slice mux.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the frame)
//   cap_en     : capture d into the frame register this cycle
//   d          : full result frame
//   sel        : channel to present on q
//   q          : channel slice of the stored frame (combinational from register)
// -----------------------------------------------------------------------------
module cube_frame_reg
    import cube_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap_en,
    input  logic [FRAME_W-1:0] d,
    input  logic [CH_W-1:0]    sel,
    output logic [BEAT_W-1:0]  q
);

    logic [FRAME_W-1:0] frame_r;
    logic [BEAT_W-1:0]  chans_s [NUM_CH];

    // Frame storage: whole frame captured in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r <= '0;
        end else if (cap_en) begin
            frame_r <= d;
        end else begin
            frame_r <= frame_r;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign chans_s[g] = frame_r[g*BEAT_W +: BEAT_W];
    end

    // Channel-slice mux.
    always_comb begin
        q = chans_s[sel];
    end

endmodule

// File: rtl/cube_result_writer.sv
// -----------------------------------------------------------------------------
// cube_result_writer
// Captures one wide ELU result frame on a load strobe and streams it out one
// channel per beat over a valid/ready interface.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : one-cycle frame-valid strobe
//   d           : result frame, channel c at [(c+1)*BEAT_W-1 : c*BEAT_W]
//   out_ready   : downstream accepts a beat
//   clr_ovf     : synchronous clear of overflow (a same-cycle drop wins)
//   out_valid   : out_data holds a valid beat
//   out_data    : current channel slice
//   out_ch      : index of the channel on out_data
//   out_last    : final beat of the frame
//   frame_done  : one-cycle pulse after the final beat is accepted
//   busy        : a frame is held or being sent
//   overflow    : sticky, a load was dropped
// Build option CUBE_WRITER_DBLBUF_EN adds a shadow frame register so one load
// arriving mid-stream is held and promoted without a bubble. The two frame
// registers ping-pong: act_r selects the one being streamed.
// All outputs are registered. The first beat is taken straight from d so it
// appears one cycle after load; later beats come from the frame register,
// which is read one channel ahead of out_ch.
// -----------------------------------------------------------------------------
module cube_result_writer
    import cube_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] d,
    input  logic               out_ready,
    input  logic               clr_ovf,
    output logic               out_valid,
    output logic [BEAT_W-1:0]  out_data,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_last,
    output logic               frame_done,
    output logic               busy,
    output logic               overflow
);

    localparam logic FIRST_IS_LAST = 1'(NUM_CH == 1);

    wr_state_e         state_r;
    logic              out_valid_r;
    logic [BEAT_W-1:0] out_data_r;
    logic [CH_W-1:0]   out_ch_r;
    logic              out_last_r;
    logic              frame_done_r;
    logic              busy_r;
    logic              overflow_r;

    logic              xfer_s;
    logic              final_s;
    logic              start_s;
    logic              promote_s;
    logic              drop_s;
    logic [CH_W-1:0]   ch_inc_s;
    logic [BEAT_W-1:0] act_slice_s;
    logic [BEAT_W-1:0] shd_slice_s;

    // Handshake decode shared by both builds.
    always_comb begin
        xfer_s   = out_valid_r && out_ready;
        final_s  = xfer_s && out_last_r;
        ch_inc_s = out_ch_r + CH_W'(1);
    end

`ifdef CUBE_WRITER_DBLBUF_EN

    logic              act_r;
    logic              shd_full_r;
    logic [1:0]        cap_en_s;
    logic              shd_set_s;
    logic              shd_clr_s;
    logic [CH_W-1:0]   sel_s     [2];
    logic [BEAT_W-1:0] frame_q_s [2];

    cube_frame_reg u_frame0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap_en (cap_en_s[0]),
        .d      (d),
        .sel    (sel_s[0]),
        .q      (frame_q_s[0])
    );

    cube_frame_reg u_frame1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap_en (cap_en_s[1]),
        .d      (d),
        .sel    (sel_s[1]),
        .q      (frame_q_s[1])
    );

    // Load routing: into the active register when starting, into the shadow
    // while streaming, and into the freed register when the shadow is promoted.
    always_comb begin
        start_s   = 1'b0;
        promote_s = 1'b0;
        drop_s    = 1'b0;
        cap_en_s  = 2'b00;
        shd_set_s = 1'b0;
        shd_clr_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (load) begin
                start_s          = 1'b1;
                cap_en_s[act_r]  = 1'b1;
            end else begin
                start_s          = 1'b0;
            end
        end else if (final_s) begin
            if (shd_full_r) begin
                promote_s = 1'b1;
                if (load) begin
                    cap_en_s[act_r] = 1'b1;
                end else begin
                    shd_clr_s       = 1'b1;
                end
            end else if (load) begin
                start_s         = 1'b1;
                cap_en_s[act_r] = 1'b1;
            end else begin
                start_s         = 1'b0;
            end
        end else begin
            if (load && !shd_full_r) begin
                cap_en_s[~act_r] = 1'b1;
                shd_set_s        = 1'b1;
            end else if (load) begin
                drop_s           = 1'b1;
            end else begin
                drop_s           = 1'b0;
            end
        end
    end

    // Active register is read one channel ahead; shadow is parked on channel 0
    // so its first beat is ready at promotion.
    always_comb begin
        sel_s[0]    = '0;
        sel_s[1]    = '0;
        sel_s[act_r] = ch_inc_s;
        act_slice_s = act_r ? frame_q_s[1] : frame_q_s[0];
        shd_slice_s = act_r ? frame_q_s[0] : frame_q_s[1];
    end

    // Ping-pong pointer and shadow occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r      <= 1'b0;
            shd_full_r <= 1'b0;
        end else begin
            if (promote_s) begin
                act_r <= ~act_r;
            end
            if (shd_set_s) begin
                shd_full_r <= 1'b1;
            end else if (shd_clr_s) begin
                shd_full_r <= 1'b0;
            end
        end
    end

`else

    logic              cap_en_s;

    cube_frame_reg u_frame0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap_en (cap_en_s),
        .d      (d),
        .sel    (ch_inc_s),
        .q      (act_slice_s)
    );

    // Single register: a load is taken only when idle or on the final transfer.
    always_comb begin
        start_s     = load && ((state_r == ST_IDLE) || final_s);
        drop_s      = load && !start_s;
        promote_s   = 1'b0;
        cap_en_s    = start_s;
        shd_slice_s = '0;
    end

`endif

    // Stream state, output beat registers, done pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_ch_r     <= '0;
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            frame_done_r <= final_s;

            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end

            if (start_s) begin
                state_r     <= ST_SEND;
                busy_r      <= 1'b1;
                out_valid_r <= 1'b1;
                out_ch_r    <= '0;
                out_data_r  <= d[BEAT_W-1:0];
                out_last_r  <= FIRST_IS_LAST;
            end else if (promote_s) begin
                state_r     <= ST_SEND;
                busy_r      <= 1'b1;
                out_valid_r <= 1'b1;
                out_ch_r    <= '0;
                out_data_r  <= shd_slice_s;
                out_last_r  <= FIRST_IS_LAST;
            end else if (final_s) begin
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                out_valid_r <= 1'b0;
                out_ch_r    <= '0;
                out_data_r  <= '0;
                out_last_r  <= 1'b0;
            end else if (xfer_s) begin
                out_ch_r    <= ch_inc_s;
                out_data_r  <= act_slice_s;
                out_last_r  <= is_last_ch(ch_inc_s);
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_ch     = out_ch_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_cube_result_writer.sv
// -----------------------------------------------------------------------------
// tb_cube_result_writer
// Directed and randomized stimulus for cube_result_writer. The reference model
// keeps held frames in a queue (capacity 1, or 2 with CUBE_WRITER_DBLBUF_EN)
// and a beat index into the head frame.
// -----------------------------------------------------------------------------
module tb_cube_result_writer;
    import cube_pkg::*;

`ifdef CUBE_WRITER_DBLBUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               load = 1'b0;
    logic [FRAME_W-1:0] d = '0;
    logic               out_ready = 1'b0;
    logic               clr_ovf = 1'b0;
    logic               out_valid;
    logic [BEAT_W-1:0]  out_data;
    logic [CH_W-1:0]    out_ch;
    logic               out_last;
    logic               frame_done;
    logic               busy;
    logic               overflow;

    always #5 clk = ~clk;

    cube_result_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .d          (d),
        .out_ready  (out_ready),
        .clr_ovf    (clr_ovf),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [FRAME_W-1:0] m_q[$];
    int                 m_ch   = 0;
    logic               m_done = 1'b0;
    logic               m_ovf  = 1'b0;

    int   dut_xfers = 0;
    int   dut_done  = 0;
    int   vcnt      = 0;
    logic count_en  = 1'b0;

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        for (int i = 0; i < FRAME_W / 32; i++) f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] pattern_frame();
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int e = 0; e < CH_ELEMS; e++)
                f[(c*CH_ELEMS + e)*DATA_LEN +: DATA_LEN] = {8'(c), 8'(e)};
        return f;
    endfunction

    function automatic logic [BEAT_W-1:0] slice_of(input logic [FRAME_W-1:0] f, input int c);
        return f[c*BEAT_W +: BEAT_W];
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs applied to it.
    task automatic model_update();
        logic xfer, fin, drop;
        xfer = (m_q.size() > 0) && out_ready;
        fin  = xfer && (m_ch == NUM_CH - 1);
        if (fin) begin
            void'(m_q.pop_front());
            m_ch = 0;
        end else if (xfer) begin
            m_ch++;
        end
        drop = 1'b0;
        if (load) begin
            if (m_q.size() < CAP) m_q.push_back(d);
            else drop = 1'b1;
        end
        if (m_q.size() == 0) m_ch = 0;
        m_done = fin;
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ch   = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic              v;
        logic [BEAT_W-1:0] ed;
        v  = (m_q.size() > 0);
        ed = v ? slice_of(m_q[0], m_ch) : '0;
        chk({tag, ".valid"},    256'(out_valid),  256'(v));
        chk({tag, ".ch"},       256'(out_ch),     256'(v ? m_ch : 0));
        chk({tag, ".data"},     256'(out_data),   256'(ed));
        chk({tag, ".last"},     256'(out_last),   256'(v && (m_ch == NUM_CH - 1)));
        chk({tag, ".done"},     256'(frame_done), 256'(m_done));
        chk({tag, ".busy"},     256'(busy),       256'(v));
        chk({tag, ".overflow"}, 256'(overflow),   256'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"},    256'(out_valid),  256'(0));
        chk({tag, ".ch"},       256'(out_ch),     256'(0));
        chk({tag, ".data"},     256'(out_data),   256'(0));
        chk({tag, ".last"},     256'(out_last),   256'(0));
        chk({tag, ".done"},     256'(frame_done), 256'(0));
        chk({tag, ".busy"},     256'(busy),       256'(0));
        chk({tag, ".overflow"}, 256'(overflow),   256'(0));
    endtask

    // Apply current inputs for one edge, advance the model, then check.
    task automatic step(input string tag);
        if (out_valid && out_ready) dut_xfers++;
        @(posedge clk);
        model_update();
        #1;
        if (frame_done) dut_done++;
        if (count_en && out_valid) vcnt++;
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        load      = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3*NUM_CH && m_q.size() > 0; i++) step(tag);
        chk({tag, ".drained"}, 256'(m_q.size()), 256'(0));
    endtask

    initial begin
        logic [FRAME_W-1:0] f1;
        logic [FRAME_W-1:0] f2;
        logic [3:0]         rpat;

        // Reset state
        rst_n = 1'b0;
        #12;
        check_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");

        // Basic stream with the {channel,element} pattern
        out_ready = 1'b1;
        d         = pattern_frame();
        load      = 1'b1;
        dut_done  = 0;
        step("basic.load");
        load = 1'b0;
        chk("basic.first_ch", 256'(out_ch), 256'(0));
        chk("basic.first_valid", 256'(out_valid), 256'(1));
        for (int i = 1; i <= NUM_CH; i++) begin
            step("basic");
            if (i == 5) chk("basic.ch5e3", 256'(out_data[3*DATA_LEN +: DATA_LEN]), 256'(16'h0503));
            if (i == NUM_CH - 1) chk("basic.last", 256'(out_last), 256'(1));
        end
        chk("basic.done", 256'(frame_done), 256'(1));
        step("basic.tail");
        chk("basic.busy_fall", 256'(busy), 256'(0));
        chk("basic.done_cnt", 256'(dut_done), 256'(1));

        // Backpressure: out_ready 1,0,0,1 repeating
        rpat      = 4'b1001;
        dut_xfers = 0;
        d         = rand_frame();
        load      = 1'b1;
        step("bp.load");
        load = 1'b0;
        for (int t = 0; t < 8*NUM_CH && m_q.size() > 0; t++) begin
            out_ready = rpat[t % 4];
            step("bp");
        end
        out_ready = 1'b1;
        step("bp.tail");
        chk("bp.xfers", 256'(dut_xfers), 256'(NUM_CH));

        // Back-to-back frames
        f1       = rand_frame();
        f2       = rand_frame();
        dut_done = 0;
        d        = f1;
        load     = 1'b1;
        step("b2b.load1");
        load = 1'b0;
        for (int i = 0; i < 2*NUM_CH && m_ch != NUM_CH - 1; i++) step("b2b");
        d    = f2;
        load = 1'b1;
        step("b2b.load2");
        load = 1'b0;
        chk("b2b.valid", 256'(out_valid), 256'(1));
        chk("b2b.ch0", 256'(out_ch), 256'(0));
        chk("b2b.data0", 256'(out_data), 256'(slice_of(f2, 0)));
        chk("b2b.done", 256'(frame_done), 256'(1));
        chk("b2b.ovf", 256'(overflow), 256'(0));
        drain("b2b.drain");
        chk("b2b.done_cnt", 256'(dut_done), 256'(2));

`ifndef CUBE_WRITER_DBLBUF_EN
        // Overflow: load at beat 10 is dropped, stream continues
        f1   = rand_frame();
        d    = f1;
        load = 1'b1;
        step("ovf.load");
        load = 1'b0;
        for (int i = 0; i < 2*NUM_CH && m_ch != 10; i++) step("ovf");
        d    = rand_frame();
        load = 1'b1;
        step("ovf.drop");
        load = 1'b0;
        chk("ovf.set", 256'(overflow), 256'(1));
        chk("ovf.ch11", 256'(out_data), 256'(slice_of(f1, 11)));
        drain("ovf.drain");
        clr_ovf = 1'b1;
        step("ovf.clr");
        clr_ovf = 1'b0;
        chk("ovf.cleared", 256'(overflow), 256'(0));

        // Drop and clear in the same cycle: drop wins
        d    = rand_frame();
        load = 1'b1;
        step("ovfw.load");
        d       = rand_frame();
        clr_ovf = 1'b1;
        step("ovfw.both");
        load    = 1'b0;
        clr_ovf = 1'b0;
        chk("ovfw.stays", 256'(overflow), 256'(1));
        drain("ovfw.drain");
        clr_ovf = 1'b1;
        step("ovfw.clr");
        clr_ovf = 1'b0;
`endif

        // Reset in the middle of a frame
        d    = rand_frame();
        load = 1'b1;
        step("rstm.load");
        load = 1'b0;
        for (int i = 0; i < 2*NUM_CH && m_ch != 17; i++) step("rstm");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rstm.async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rstm.held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step("rstm.after");

`ifdef CUBE_WRITER_DBLBUF_EN
        // Shadow register: load at beat 4 held, load at beat 20 dropped
        f1       = rand_frame();
        f2       = rand_frame();
        vcnt     = 0;
        count_en = 1'b1;
        d        = f1;
        load     = 1'b1;
        step("dbl.load1");
        load = 1'b0;
        for (int i = 0; i < 2*NUM_CH && m_ch != 4; i++) step("dbl");
        d    = f2;
        load = 1'b1;
        step("dbl.load2");
        load = 1'b0;
        chk("dbl.no_ovf", 256'(overflow), 256'(0));
        chk("dbl.busy", 256'(busy), 256'(1));
        for (int i = 0; i < 2*NUM_CH && m_ch != 20; i++) step("dbl");
        d    = rand_frame();
        load = 1'b1;
        step("dbl.load3");
        load = 1'b0;
        chk("dbl.ovf", 256'(overflow), 256'(1));
        for (int i = 0; i < 2*NUM_CH && m_ch != NUM_CH - 1; i++) step("dbl");
        step("dbl.promote");
        chk("dbl.promo_valid", 256'(out_valid), 256'(1));
        chk("dbl.promo_ch", 256'(out_ch), 256'(0));
        chk("dbl.promo_data", 256'(out_data), 256'(slice_of(f2, 0)));
        for (int i = 0; i < NUM_CH + 4; i++) step("dbl.tail");
        count_en = 1'b0;
        chk("dbl.beats", 256'(vcnt), 256'(2*NUM_CH));
        clr_ovf = 1'b1;
        step("dbl.clr");
        clr_ovf = 1'b0;
`endif

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            load      = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 31) == 0);
            if (load) d = rand_frame();
            step("rand");
        end
        drain("rand.drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
